// File: rtl/multicycle_controller_if.sv
// Fetch/data memory handshake bundle plus the IR contents seen by the sequencer.
interface multicycle_controller_if;
  logic [31:0] inst;
  logic        imem_req;
  logic        imem_ready;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;

  modport master (
    input  inst, imem_ready, dmem_ready,
    output imem_req, ir_we, dmem_req, dmem_we
  );

  modport slave (
    output inst, imem_ready, dmem_ready,
    input  imem_req, ir_we, dmem_req, dmem_we
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// branch evaluation, a memory-wait watchdog and sticky trap flags.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ALUOP_W = 2,
  parameter int unsigned RET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_controller_if.master bus,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic                 alu_src,
  output logic [1:0]           mem_to_reg,
  output logic                 reg_write,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic [2:0]           state,
  output logic                 retire,
  output logic [RET_W-1:0]     retired_cnt,
  output logic                 illegal,
  output logic                 timeout
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_L     = 7'h03;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             set_illegal, set_timeout;

  logic               imem_req_c, ir_we_c, dmem_req_c, dmem_we_c;
  logic [ALUOP_W-1:0] alu_op_c;
  logic               alu_src_c, reg_write_c, pc_we_c, retire_c;
  logic [1:0]         mem_to_reg_c, pc_src_c;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_l, is_s, is_b, is_lui, is_auipc, is_jal, is_jalr;
  logic       legal, taken;
  logic       unused_inst_bits;

  assign opcode   = bus.inst[6:0];
  assign funct3   = bus.inst[14:12];
  assign unused_inst_bits = ^{bus.inst[31:15], bus.inst[11:7]};

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_l     = (opcode == OP_L);
  assign is_s     = (opcode == OP_S);
  assign is_b     = (opcode == OP_B);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);

  // funct3 010/011 are not branch encodings
  assign legal = is_r | is_i | is_l | is_s | is_lui | is_auipc | is_jal | is_jalr |
                 (is_b & (funct3 != 3'b010) & (funct3 != 3'b011));

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  // State register, watchdog, retire counter and sticky trap flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      wait_q      <= '0;
      retired_cnt <= '0;
      illegal     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire_c)    retired_cnt <= retired_cnt + RET_W'(1);
      if (set_illegal) illegal     <= 1'b1;
      if (set_timeout) timeout     <= 1'b1;
    end
  end

  // Next state and strobes; the watchdog only survives while a wait state holds
  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    set_illegal  = 1'b0;
    set_timeout  = 1'b0;
    imem_req_c   = 1'b0;
    ir_we_c      = 1'b0;
    dmem_req_c   = 1'b0;
    dmem_we_c    = 1'b0;
    alu_op_c     = '0;
    alu_src_c    = 1'b0;
    reg_write_c  = 1'b0;
    pc_we_c      = 1'b0;
    pc_src_c     = 2'd0;
    mem_to_reg_c = 2'd0;
    retire_c     = 1'b0;

    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      if (is_r)                alu_op_c = ALUOP_W'(2'b10);
      else if (is_i || is_lui) alu_op_c = ALUOP_W'(2'b11);
      else if (is_b)           alu_op_c = ALUOP_W'(2'b01);
      else                     alu_op_c = ALUOP_W'(2'b00);
      alu_src_c = is_i | is_l | is_s | is_lui | is_auipc | is_jalr;
    end

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = S_TRAP;
          set_timeout = 1'b1;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d     = S_TRAP;
          set_illegal = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_b) begin
          pc_we_c  = 1'b1;
          pc_src_c = taken ? 2'd1 : 2'd0;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (is_l || is_s) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_s;
        if (bus.dmem_ready) begin
          if (is_s) begin
            pc_we_c  = 1'b1;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d     = S_TRAP;
          set_timeout = 1'b1;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        pc_we_c      = 1'b1;
        retire_c     = 1'b1;
        mem_to_reg_c = is_l ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        pc_src_c     = is_jal ? 2'd2 : (is_jalr ? 2'd3 : 2'd0);
        state_d      = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are forced low for as long as reset is held
  assign bus.imem_req = rst_n & imem_req_c;
  assign bus.ir_we    = rst_n & ir_we_c;
  assign bus.dmem_req = rst_n & dmem_req_c;
  assign bus.dmem_we  = rst_n & dmem_we_c;
  assign alu_op       = rst_n ? alu_op_c : '0;
  assign alu_src      = rst_n & alu_src_c;
  assign mem_to_reg   = rst_n ? mem_to_reg_c : 2'd0;
  assign reg_write    = rst_n & reg_write_c;
  assign pc_we        = rst_n & pc_we_c;
  assign pc_src       = rst_n ? pc_src_c : 2'd0;
  assign retire       = rst_n & retire_c;
  assign state        = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: instruction-level model expands each
// instruction into its expected per-cycle trace, checked every cycle.
module tb_multicycle_controller;
  localparam int TIMEOUT = 16;
  localparam int RET_W   = 4;

  localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4, ST_T = 3'd5;
  localparam int C_R = 0, C_I = 1, C_L = 2, C_S = 3, C_B = 4, C_LUI = 5, C_AUIPC = 6,
                 C_JAL = 7, C_JALR = 8, C_ILL = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic [1:0] alu_op;
  logic alu_src, reg_write, pc_we, retire, illegal, timeout;
  logic [1:0] mem_to_reg, pc_src;
  logic [2:0] state;
  logic [RET_W-1:0] retired_cnt;

  multicycle_controller_if bus();

  multicycle_controller #(.TIMEOUT(TIMEOUT), .ALUOP_W(2), .RET_W(RET_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master),
    .zero(zero), .lt(lt), .ltu(ltu),
    .alu_op(alu_op), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .pc_we(pc_we), .pc_src(pc_src), .state(state),
    .retire(retire), .retired_cnt(retired_cnt), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        imem_ready, dmem_ready, zero, lt, ltu;
    logic [31:0] inst;
    logic [2:0]  st;
    logic        imem_req, ir_we, dmem_req, dmem_we, reg_write, pc_we, retire;
    logic [1:0]  pc_src, mem_to_reg, alu_op;
    logic        alu_src, chk_alu;
    logic [RET_W-1:0] rc;
    logic        ill, to;
  } cyc_t;

  cyc_t q[$];
  cyc_t cur;
  logic cur_valid = 1'b0;
  logic fresh = 1'b0;
  int   n_tests = 0, n_fail = 0;
  int   m_ret = 0;
  logic m_ill = 1'b0, m_to = 1'b0;
  logic [31:0] prev = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle with a trace entry applied: DUT must match the model
  always @(negedge clk) begin
    if (cur_valid && rst_n) begin
      chk("state",       32'(state),         32'(cur.st));
      chk("imem_req",    32'(bus.imem_req),  32'(cur.imem_req));
      chk("ir_we",       32'(bus.ir_we),     32'(cur.ir_we));
      chk("dmem_req",    32'(bus.dmem_req),  32'(cur.dmem_req));
      chk("dmem_we",     32'(bus.dmem_we),   32'(cur.dmem_we));
      chk("reg_write",   32'(reg_write),     32'(cur.reg_write));
      chk("pc_we",       32'(pc_we),         32'(cur.pc_we));
      chk("pc_src",      32'(pc_src),        32'(cur.pc_src));
      chk("mem_to_reg",  32'(mem_to_reg),    32'(cur.mem_to_reg));
      chk("retire",      32'(retire),        32'(cur.retire));
      chk("retired_cnt", 32'(retired_cnt),   32'(cur.rc));
      chk("illegal",     32'(illegal),       32'(cur.ill));
      chk("timeout",     32'(timeout),       32'(cur.to));
      if (cur.chk_alu) begin
        chk("alu_op",  32'(alu_op),  32'(cur.alu_op));
        chk("alu_src", 32'(alu_src), 32'(cur.alu_src));
      end
    end
  end

  function automatic int cls(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (ins[6:0])
      7'h33: return C_R;
      7'h13: return C_I;
      7'h03: return C_L;
      7'h23: return C_S;
      7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? C_ILL : C_B;
      7'h37: return C_LUI;
      7'h17: return C_AUIPC;
      7'h6F: return C_JAL;
      7'h67: return C_JALR;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic s, input logic u);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return s;
      3'd5: return !s;
      3'd6: return u;
      default: return !u;
    endcase
  endfunction

  function automatic cyc_t mk(input logic [2:0] st, input logic [31:0] ins);
    cyc_t c;
    c = '{default: '0};
    c.st = st;
    c.inst = ins;
    c.imem_ready = 1'($urandom);
    c.dmem_ready = 1'($urandom);
    c.zero = 1'($urandom);
    c.lt   = 1'($urandom);
    c.ltu  = 1'($urandom);
    return c;
  endfunction

  function automatic cyc_t with_alu(input cyc_t c, input int k);
    cyc_t r;
    r = c;
    if (k != C_JAL) begin
      r.chk_alu = 1'b1;
      r.alu_op  = (k == C_R) ? 2'b10 : (k == C_I || k == C_LUI) ? 2'b11 : (k == C_B) ? 2'b01 : 2'b00;
      r.alu_src = !(k == C_R || k == C_B);
    end
    return r;
  endfunction

  task automatic push(input cyc_t c);
    cyc_t e;
    e = c;
    e.rc  = RET_W'(m_ret);
    e.ill = m_ill;
    e.to  = m_to;
    q.push_back(e);
    if (c.retire) m_ret++;
  endtask

  task automatic trap_tail(input logic [31:0] ins);
    for (int i = 0; i < 4; i++) push(mk(ST_T, ins));
  endtask

  // Expand one instruction into its expected cycle trace
  task automatic gen(input logic [31:0] ins, input int fw, input int dw, input int zf);
    cyc_t c;
    int k;
    k = cls(ins);
    for (int i = 0; i < fw && i < TIMEOUT; i++) begin
      c = mk(ST_F, prev); c.imem_ready = 1'b0; c.imem_req = 1'b1; push(c);
    end
    if (fw >= TIMEOUT) begin m_to = 1'b1; trap_tail(prev); return; end
    c = mk(ST_F, prev); c.imem_ready = 1'b1; c.imem_req = 1'b1; c.ir_we = 1'b1; push(c);
    prev = ins;
    push(mk(ST_D, ins));
    if (k == C_ILL) begin m_ill = 1'b1; trap_tail(ins); return; end
    c = with_alu(mk(ST_E, ins), k);
    if (k == C_B) begin
      if (zf >= 0) c.zero = zf[0];
      c.pc_we  = 1'b1;
      c.pc_src = branch_taken(ins[14:12], c.zero, c.lt, c.ltu) ? 2'd1 : 2'd0;
      c.retire = 1'b1;
      push(c);
      return;
    end
    push(c);
    if (k == C_L || k == C_S) begin
      for (int i = 0; i < dw && i < TIMEOUT; i++) begin
        c = mk(ST_M, ins); c.dmem_ready = 1'b0; c.dmem_req = 1'b1; c.dmem_we = (k == C_S); push(c);
      end
      if (dw >= TIMEOUT) begin m_to = 1'b1; trap_tail(ins); return; end
      c = mk(ST_M, ins); c.dmem_ready = 1'b1; c.dmem_req = 1'b1; c.dmem_we = (k == C_S);
      if (k == C_S) begin c.pc_we = 1'b1; c.retire = 1'b1; push(c); return; end
      push(c);
    end
    c = with_alu(mk(ST_W, ins), k);
    c.reg_write  = 1'b1;
    c.pc_we      = 1'b1;
    c.retire     = 1'b1;
    c.mem_to_reg = (k == C_L) ? 2'd1 : (k == C_JAL || k == C_JALR) ? 2'd2 : 2'd0;
    c.pc_src     = (k == C_JAL) ? 2'd2 : (k == C_JALR) ? 2'd3 : 2'd0;
    push(c);
  endtask

  task automatic run_q(input int maxn);
    int n;
    n = 0;
    while (q.size() > 0 && n < maxn) begin
      if (!fresh) begin @(posedge clk); #1; end
      fresh = 1'b0;
      cur = q.pop_front();
      bus.imem_ready = cur.imem_ready;
      bus.dmem_ready = cur.dmem_ready;
      bus.inst = cur.inst;
      zero = cur.zero; lt = cur.lt; ltu = cur.ltu;
      cur_valid = 1'b1;
      n++;
    end
  endtask

  // Asynchronous reset mid-cycle; strobes must drop before the next edge
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    cur_valid = 1'b0;
    q.delete();
    m_ret = 0; m_ill = 1'b0; m_to = 1'b0;
    bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_state",    32'(state),        32'd0);
      chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
      chk("rst_ir_we",    32'(bus.ir_we),    32'd0);
      chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
      chk("rst_pc_we",    32'(pc_we),        32'd0);
      chk("rst_reg_wr",   32'(reg_write),    32'd0);
      chk("rst_retire",   32'(retire),       32'd0);
      chk("rst_cnt",      32'(retired_cnt),  32'd0);
      chk("rst_illegal",  32'(illegal),      32'd0);
      chk("rst_timeout",  32'(timeout),      32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    fresh = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int k, fw, dw;
    logic [31:0] ins;
    bus.inst = 32'h0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    do_reset();

    // add: F,D,E,WB
    gen(32'h002081B3, 0, 0, -1);
    chk("model_add_len", 32'(q.size()), 32'd4);
    chk("model_add_wb_m2r", 32'(q[3].mem_to_reg), 32'd0);
    chk("model_add_wb_alu", 32'(q[3].alu_op), 32'd2);
    run_q(100);

    // lw with three wait cycles
    gen(32'h0000A183, 0, 3, -1);
    chk("model_lw_len", 32'(q.size()), 32'd8);
    chk("model_lw_rc_after_add", 32'(q[0].rc), 32'd1);
    chk("model_lw_wb_m2r", 32'(q[7].mem_to_reg), 32'd1);
    run_q(100);

    // bne not taken / taken
    gen(32'h00001463, 0, 0, 1);
    chk("model_bne_len", 32'(q.size()), 32'd3);
    chk("model_bne_nt_src", 32'(q[2].pc_src), 32'd0);
    run_q(100);
    gen(32'h00001463, 0, 0, 0);
    chk("model_bne_t_src", 32'(q[2].pc_src), 32'd1);
    chk("model_bne_alu", 32'(q[2].alu_op), 32'd1);
    run_q(100);

    // unsupported opcode traps and stays trapped
    gen(32'h0000007F, 0, 0, -1);
    chk("model_ill_flag", 32'(q[q.size()-1].ill), 32'd1);
    run_q(100);
    do_reset();

    // fetch watchdog: expires, then ready on the last allowed cycle
    gen(32'h002081B3, TIMEOUT, 0, -1);
    chk("model_to_len", 32'(q.size()), 32'(TIMEOUT + 4));
    run_q(100);
    do_reset();
    gen(32'h002081B3, TIMEOUT - 1, 0, -1);
    chk("model_late_ready_len", 32'(q.size()), 32'(TIMEOUT - 1 + 4));
    run_q(100);

    // reset falling at the start of WB aborts the write
    gen(32'h002081B3, 0, 0, -1);
    run_q(3);
    do_reset();

    // 17 retirements on a 4-bit counter wrap to 1
    repeat (17) begin gen(32'h002081B3, 0, 0, -1); run_q(100); end
    gen(32'h002081B3, 0, 0, -1);
    chk("model_wrap_rc", 32'(q[0].rc), 32'd1);
    run_q(100);

    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      k = $urandom_range(0, 10);
      case (k)
        0: ins[6:0] = 7'h33;  1: ins[6:0] = 7'h13;  2: ins[6:0] = 7'h03;
        3: ins[6:0] = 7'h23;  4, 9: ins[6:0] = 7'h63; 5: ins[6:0] = 7'h37;
        6: ins[6:0] = 7'h17;  7: ins[6:0] = 7'h6F;  8: ins[6:0] = 7'h67;
        default: ;
      endcase
      k  = $urandom_range(0, 39);
      fw = (k == 0) ? TIMEOUT : (k == 1) ? TIMEOUT - 1 : $urandom_range(0, 3);
      k  = $urandom_range(0, 39);
      dw = (k == 0) ? TIMEOUT : (k == 1) ? TIMEOUT - 1 : $urandom_range(0, 3);
      gen(ins, fw, dw, -1);
      if ($urandom_range(0, 29) == 0) begin
        run_q($urandom_range(1, 4));
        do_reset();
      end else begin
        run_q(100);
        if (m_ill || m_to) do_reset();
      end
    end

    @(posedge clk); #1;
    cur_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle RV32I control unit: a sequencer FSM that drives the shared datapath through FETCH/DECODE/EXEC/MEM/WB.
- Adds ready/req handshakes to instruction and data memory, full branch-condition evaluation (all six funct3 cases), a timeout watchdog and sticky trap reporting.
- Sits between the IR/PC/ALU datapath and the memory interfaces, and replaces the single-cycle combinational decoder.

Parameters:
- TIMEOUT, 16: max cycles a memory req may wait without ready before trapping; range 2..255.
- ALUOP_W, 2: alu_op width. Encoding 00 add (L/S/AUIPC/JALR), 01 sub/compare (B), 10 R-funct, 11 I-funct/LUI.
- RET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst  in  32  IR contents from datapath; valid from the cycle after ir_we.
- zero  in  1  ALU result == 0.
- lt  in  1  signed rs1<rs2.
- ltu  in  1  unsigned rs1<rs2.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid this cycle.
- ir_we  out  1  latch instruction into IR.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store.
- dmem_ready  in  1  access complete this cycle.
- alu_op  out  ALUOP_W  ALU operation class.
- alu_src  out  1  operand B = immediate.
- mem_to_reg  out  2  0 ALU, 1 mem data, 2 PC+4.
- reg_write  out  1  register-file write strobe.
- pc_we  out  1  PC update strobe.
- pc_src  out  2  0 PC+4, 1 branch target, 2 JAL target, 3 JALR target (LSB cleared by datapath).
- state  out  3  current FSM state (debug).
- retire  out  1  one-cycle pulse per completed instruction.
- retired_cnt  out  RET_W  retired-instruction count, wraps modulo 2^RET_W.
- illegal  out  1  sticky: unsupported opcode.
- timeout  out  1  sticky: memory watchdog expired.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 are unreachable and recover to FETCH on the next edge.
- Reset (async, rst_n low): state=FETCH, wait counter=0, retired_cnt=0, illegal=0, timeout=0. All strobes 0 while rst_n is low, including imem_req.
- All strobes and mux selects are combinational from state and the registered inst opcode/funct3. The reset value of every select and strobe is 0.
- FETCH: imem_req=1. On imem_ready: ir_we=1 for that cycle, go to DECODE. Otherwise stay.
- DECODE:
  - opcode not in {0x33,0x13,0x03,0x23,0x63,0x37,0x17,0x6F,0x67} -> TRAP, set illegal.
  - B with funct3 010 or 011 -> TRAP, set illegal.
  - Otherwise -> EXEC.
- EXEC: alu_op and alu_src valid.
  - B: taken = beq zero, bne !zero, blt lt, bge !lt, bltu ltu, bgeu !ltu. pc_we=1, pc_src=taken?1:0, retire=1, go to FETCH.
  - L or S: go to MEM.
  - All others: go to WB.
- MEM: dmem_req=1, dmem_we=(S). Wait for dmem_ready.
  - S: pc_we=1, pc_src=0, retire=1, go to FETCH.
  - L: go to WB.
- WB: reg_write=1, pc_we=1, retire=1, then FETCH.
  - mem_to_reg: 1 for L, 2 for JAL/JALR, 0 otherwise.
  - pc_src: 2 for JAL, 3 for JALR, 0 otherwise.
- Latency, when imem_ready and dmem_ready are asserted on the first request cycle: B=3, R/I/U/S/J=4, L=5 cycles.
- Watchdog: counter increments each cycle in FETCH or MEM with ready low. It clears on any state change.
  - When it reaches TIMEOUT-1 with ready still low: go to TRAP, set timeout.
  - Ready arriving on the TIMEOUT-1 cycle wins: the transfer completes and no trap is raised.
- TRAP: all strobes 0. Stays in TRAP until reset. illegal and timeout clear only on reset.
- retired_cnt increments on the clock edge ending every retire cycle, and wraps from all-ones to 0.
- Reset mid-instruction aborts immediately. No partial pc_we or reg_write occurs after rst_n falls.

Test Plan:
- Reset release, inst=0x002081B3 (add), imem_ready=1 -> states 0,1,2,4. In WB: reg_write=1, mem_to_reg=0, alu_op=10, pc_src=0. Then retired_cnt=1.
- inst=0x0000A183 (lw), dmem_ready delayed 3 cycles -> MEM held 4 cycles with dmem_req=1, dmem_we=0. WB has mem_to_reg=1. Total 8 cycles, one retire pulse.
- inst=0x00001463 (bne) with zero=1 -> pc_src=0. With zero=0 -> pc_src=1. Both take 3 cycles with alu_op=01.
- inst=0x0000007F -> DECODE to TRAP; illegal=1 sticky. imem_req stays 0 until rst_n pulses low, after which illegal=0.
- TIMEOUT=16, imem_ready held 0 -> TRAP after 16 FETCH cycles with timeout=1. A repeat run with ready on cycle 16 -> no trap.
- RET_W=4, run 17 add instructions -> retired_cnt wraps to 1.
